// File: rtl/ws2812_rx.sv
// WS2812 single-wire NRZ decoder: measures high pulse widths, assembles
// MSB-first 24-bit GRB words and detects the low latch gap ending a frame.
module ws2812_rx #(
    parameter int BIT_THRESH   = 15,
    parameter int MIN_HIGH     = 3,
    parameter int MAX_HIGH     = 40,
    parameter int RESET_CYCLES = 1250,
    parameter int CNT_W        = 16
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             din,
    output logic [23:0]      data,
    output logic             data_valid,
    output logic             latch,
    output logic             err,
    output logic [CNT_W-1:0] pixel_count
);

    localparam int HW = $clog2(MAX_HIGH + 2);
    localparam int LW = $clog2(RESET_CYCLES + 1);

    localparam logic [HW-1:0] H_SAT    = HW'(MAX_HIGH + 1);
    localparam logic [HW-1:0] H_MAX    = HW'(MAX_HIGH);
    localparam logic [HW-1:0] H_MIN    = HW'(MIN_HIGH);
    localparam logic [HW-1:0] H_THRESH = HW'(BIT_THRESH);
    localparam logic [LW-1:0] L_SAT    = LW'(RESET_CYCLES);
    localparam logic [LW-1:0] L_LAST   = LW'(RESET_CYCLES - 1);

    typedef enum logic [1:0] {
        IDLE,
        HIGH,
        LOW,
        ERR
    } state_t;

    state_t           state_q, state_d;
    logic             s1_q, s1_d;
    logic             s2_q, s2_d;
    logic             s3_q, s3_d;
    logic [HW-1:0]    hcnt_q, hcnt_d;
    logic [LW-1:0]    lcnt_q, lcnt_d;
    logic [4:0]       bitcnt_q, bitcnt_d;
    logic [23:0]      shreg_q, shreg_d;
    logic [23:0]      data_q, data_d;
    logic             data_valid_q, data_valid_d;
    logic             latch_q, latch_d;
    logic             err_q, err_d;
    logic [CNT_W-1:0] pixel_count_q, pixel_count_d;

    logic rise;
    logic fall;
    logic bit_v;

    assign rise  = s2_q & ~s3_q;
    assign fall  = ~s2_q & s3_q;
    assign bit_v = (hcnt_q >= H_THRESH);

    always_comb begin
        state_d       = state_q;
        s1_d          = din;
        s2_d          = s1_q;
        s3_d          = s2_q;
        bitcnt_d      = bitcnt_q;
        shreg_d       = shreg_q;
        data_d        = data_q;
        data_valid_d  = 1'b0;
        latch_d       = 1'b0;
        err_d         = 1'b0;
        pixel_count_d = pixel_count_q;

        // Pulse-width counters run independently of the state
        if (s2_q) begin
            hcnt_d = (hcnt_q == H_SAT) ? hcnt_q : hcnt_q + HW'(1);
        end else begin
            hcnt_d = '0;
        end
        if (!s2_q) begin
            lcnt_d = (lcnt_q == L_SAT) ? lcnt_q : lcnt_q + LW'(1);
        end else begin
            lcnt_d = '0;
        end

        unique case (state_q)
            IDLE: begin
                if (rise) begin
                    state_d = HIGH;
                end
            end
            HIGH: begin
                if (s2_q && hcnt_q == H_MAX) begin
                    err_d    = 1'b1;
                    bitcnt_d = '0;
                    state_d  = ERR;
                end else if (fall) begin
                    state_d = LOW;
                    if (hcnt_q >= H_MIN) begin
                        shreg_d = {shreg_q[22:0], bit_v};
                        if (bitcnt_q == 5'd23) begin
                            data_d        = {shreg_q[22:0], bit_v};
                            data_valid_d  = 1'b1;
                            bitcnt_d      = '0;
                            pixel_count_d = pixel_count_q + CNT_W'(1);
                        end else begin
                            bitcnt_d = bitcnt_q + 5'd1;
                        end
                    end
                end
            end
            LOW: begin
                if (rise) begin
                    state_d = HIGH;
                end else if (!s2_q && lcnt_q == L_LAST) begin
                    latch_d       = 1'b1;
                    err_d         = (bitcnt_q != 5'd0);
                    bitcnt_d      = '0;
                    pixel_count_d = '0;
                    state_d       = IDLE;
                end
            end
            ERR: begin
                if (!s2_q && lcnt_q == L_LAST) begin
                    pixel_count_d = '0;
                    state_d       = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q       <= IDLE;
            s1_q          <= 1'b0;
            s2_q          <= 1'b0;
            s3_q          <= 1'b0;
            hcnt_q        <= '0;
            lcnt_q        <= '0;
            bitcnt_q      <= '0;
            shreg_q       <= '0;
            data_q        <= '0;
            data_valid_q  <= 1'b0;
            latch_q       <= 1'b0;
            err_q         <= 1'b0;
            pixel_count_q <= '0;
        end else begin
            state_q       <= state_d;
            s1_q          <= s1_d;
            s2_q          <= s2_d;
            s3_q          <= s3_d;
            hcnt_q        <= hcnt_d;
            lcnt_q        <= lcnt_d;
            bitcnt_q      <= bitcnt_d;
            shreg_q       <= shreg_d;
            data_q        <= data_d;
            data_valid_q  <= data_valid_d;
            latch_q       <= latch_d;
            err_q         <= err_d;
            pixel_count_q <= pixel_count_d;
        end
    end

    assign data        = data_q;
    assign data_valid  = data_valid_q;
    assign latch       = latch_q;
    assign err         = err_q;
    assign pixel_count = pixel_count_q;

endmodule

// File: tb/tb_ws2812_rx.sv
// Directed bench for ws2812_rx: table of words plus hand sequences for
// latency, latch/err coincidence, overlong pulses and mid-word reset.
module tb_ws2812_rx;

    logic        clk;
    logic        reset;
    logic        din;
    logic [23:0] data;
    logic        data_valid;
    logic        latch;
    logic        err;
    logic [15:0] pixel_count;

    int checks;
    int failures;

    int          n_dv;
    int          n_latch;
    int          n_err;
    int          n_both;
    logic [23:0] last_data;
    logic [15:0] prev_pc;
    logic [15:0] pc_before_latch;

    typedef struct {
        logic [23:0] word;
        int          h0;
        int          h1;
        int          per;
        bit          glitch;
        int          exp_pc;
    } vec_t;

    vec_t vecs [6];

    ws2812_rx #(
        .BIT_THRESH  (15),
        .MIN_HIGH    (3),
        .MAX_HIGH    (40),
        .RESET_CYCLES(1250),
        .CNT_W       (16)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .din        (din),
        .data       (data),
        .data_valid (data_valid),
        .latch      (latch),
        .err        (err),
        .pixel_count(pixel_count)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    always @(negedge clk) begin
        if (data_valid) begin
            n_dv++;
            last_data = data;
        end
        if (latch) begin
            n_latch++;
            pc_before_latch = prev_pc;
        end
        if (err) n_err++;
        if (latch && err) n_both++;
        prev_pc = pixel_count;
    end

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic send_bit(input bit b, input int h0, input int h1,
                            input int per, input bit glitch);
        int h;
        h = b ? h1 : h0;
        din = 1'b1;
        repeat (h) @(negedge clk);
        din = 1'b0;
        if (glitch) begin
            repeat (4) @(negedge clk);
            din = 1'b1;
            repeat (2) @(negedge clk);
            din = 1'b0;
            repeat (per - h - 6) @(negedge clk);
        end else begin
            repeat (per - h) @(negedge clk);
        end
    endtask

    task automatic send_word(input logic [23:0] w);
        for (int i = 23; i >= 0; i--) send_bit(w[i], 10, 20, 31, 1'b0);
    endtask

    task automatic idle_low(input int n);
        din = 1'b0;
        repeat (n) @(negedge clk);
        #2;
    endtask

    initial begin
        int dv0, la0, er0, bo0, lat;
        logic [23:0] w;

        checks   = 0;
        failures = 0;
        n_dv     = 0;
        n_latch  = 0;
        n_err    = 0;
        n_both   = 0;
        last_data       = '0;
        prev_pc         = '0;
        pc_before_latch = '0;

        vecs[0] = '{24'h123456, 10, 20, 31, 1'b0, 1};
        vecs[1] = '{24'hABCDEF, 10, 20, 31, 1'b0, 2};
        vecs[2] = '{24'h000001, 10, 20, 31, 1'b0, 3};
        vecs[3] = '{24'hC3A55A, 10, 20, 31, 1'b1, 4};
        vecs[4] = '{24'hF0F0F0, 14, 15, 31, 1'b0, 5};
        vecs[5] = '{24'h0F0F0F, 3, 40, 52, 1'b0, 6};

        reset = 1'b1;
        din   = 1'b0;
        #23;
        chk("rst_data", {8'h0, data}, 32'h0);
        chk("rst_flags", {29'h0, data_valid, latch, err}, 32'h0);
        chk("rst_pc", {16'h0, pixel_count}, 32'h0);
        @(negedge clk);
        reset = 1'b0;

        // Power-up idle gap must not latch
        idle_low(1300);
        chk("idle_no_latch", n_latch, 0);

        // Word 0xFF00FF with data_valid latency measured from din fall
        dv0 = n_dv;
        w   = 24'hFF00FF;
        for (int i = 23; i >= 1; i--) send_bit(w[i], 10, 20, 31, 1'b0);
        din = 1'b1;
        repeat (20) @(negedge clk);
        din = 1'b0;
        lat = 0;
        for (int k = 1; k <= 10; k++) begin
            @(negedge clk);
            if (data_valid && lat == 0) lat = k;
        end
        #2;
        chk("dv_latency", lat, 3);
        chk("t1_dv_count", n_dv - dv0, 1);
        chk("t1_data", {8'h0, last_data}, 32'h00FF00FF);
        chk("t1_pc", {16'h0, pixel_count}, 32'd1);
        la0 = n_latch;
        idle_low(1300);
        chk("t1_latch", n_latch - la0, 1);
        chk("t1_pc_before", {16'h0, pc_before_latch}, 32'd1);
        chk("t1_pc_after", {16'h0, pixel_count}, 32'd0);
        chk("t1_no_err", n_err, 0);
        chk("t1_data_hold", {8'h0, data}, 32'h00FF00FF);

        // Table: words at nominal timing, glitches, threshold boundaries
        dv0 = n_dv;
        for (int i = 0; i < 6; i++) begin
            for (int b = 23; b >= 0; b--)
                send_bit(vecs[i].word[b], vecs[i].h0, vecs[i].h1,
                         vecs[i].per, vecs[i].glitch);
            #2;
            chk($sformatf("vec%0d_data", i), {8'h0, last_data},
                {8'h0, vecs[i].word});
            chk($sformatf("vec%0d_pc", i), {16'h0, pixel_count},
                vecs[i].exp_pc);
            chk($sformatf("vec%0d_dv", i), n_dv - dv0, i + 1);
        end
        la0 = n_latch;
        idle_low(1300);
        chk("tbl_latch", n_latch - la0, 1);
        chk("tbl_pc_before", {16'h0, pc_before_latch}, 32'd6);
        chk("tbl_no_err", n_err, 0);

        // Partial word at the gap: latch and err together
        dv0 = n_dv;
        la0 = n_latch;
        er0 = n_err;
        bo0 = n_both;
        for (int i = 0; i < 10; i++) send_bit(1'b1, 10, 20, 31, 1'b0);
        idle_low(1300);
        chk("t3_no_dv", n_dv - dv0, 0);
        chk("t3_latch", n_latch - la0, 1);
        chk("t3_err", n_err - er0, 1);
        chk("t3_both", n_both - bo0, 1);
        send_word(24'h00A5F0);
        #2;
        chk("t3_next_data", {8'h0, last_data}, 32'h0000A5F0);
        chk("t3_next_pc", {16'h0, pixel_count}, 32'd1);

        // Overlong high pulse
        la0 = n_latch;
        er0 = n_err;
        din = 1'b1;
        lat = 0;
        for (int k = 1; k <= 50; k++) begin
            @(negedge clk);
            if (err && lat == 0) lat = k;
        end
        din = 1'b0;
        chk("t5_err_time", lat, 43);
        idle_low(1300);
        chk("t5_err_count", n_err - er0, 1);
        chk("t5_no_latch", n_latch - la0, 0);
        chk("t5_pc_clr", {16'h0, pixel_count}, 32'd0);
        dv0 = n_dv;
        send_word(24'h5A5A5A);
        #2;
        chk("t5_data", {8'h0, last_data}, 32'h005A5A5A);
        chk("t5_dv", n_dv - dv0, 1);

        // Asynchronous reset mid-word
        w = 24'hFFF000;
        for (int i = 23; i >= 12; i--) send_bit(w[i], 10, 20, 31, 1'b0);
        #3;
        reset = 1'b1;
        #1;
        chk("t6_rst_data", {8'h0, data}, 32'h0);
        chk("t6_rst_pc", {16'h0, pixel_count}, 32'h0);
        chk("t6_rst_flags", {29'h0, data_valid, latch, err}, 32'h0);
        repeat (3) @(negedge clk);
        reset = 1'b0;
        dv0 = n_dv;
        er0 = n_err;
        idle_low(20);
        send_word(24'h00FF00);
        #2;
        chk("t6_data", {8'h0, last_data}, 32'h0000FF00);
        chk("t6_dv", n_dv - dv0, 1);
        chk("t6_pc", {16'h0, pixel_count}, 32'd1);
        chk("t6_no_err", n_err - er0, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
